// File: rtl/boot_sequencer_if.sv
// Signal bundle between the boot sequencer and its surroundings: memory status,
// the video clear engine, the UART byte stream, the RAM write port and boot status.
interface boot_sequencer_if;
   // Handshakes: clear_req is a level held until a one-cycle clear_ack; uart_valid
   // is a one-cycle strobe with no backpressure; wr_req/wr_addr/wr_data are held
   // stable until the cycle wr_ack=1, and that cycle completes the write.
   logic        mem_calib_done;
   logic        mem_error;
   logic        clear_ack;
   logic        uart_valid;
   logic [7:0]  uart_data;
   logic        wr_ack;
   logic        clear_req;
   logic        clear_screen_done;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        uart_load_done;
   logic [7:0]  uart_progress;
   logic        cpu_run;
   logic        boot_error;
   logic [1:0]  error_code;

   modport master (
      input  mem_calib_done, mem_error, clear_ack, uart_valid, uart_data, wr_ack,
      output clear_req, clear_screen_done, wr_req, wr_addr, wr_data,
             uart_load_done, uart_progress, cpu_run, boot_error, error_code
   );

   modport slave (
      output mem_calib_done, mem_error, clear_ack, uart_valid, uart_data, wr_ack,
      input  clear_req, clear_screen_done, wr_req, wr_addr, wr_data,
             uart_load_done, uart_progress, cpu_run, boot_error, error_code
   );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: waits for LPDDR calibration, clears video memory, streams
// LOAD_BYTES UART bytes into RAM, then enables the CPU; any fault latches ERROR.
module boot_sequencer #(
   parameter int LOAD_BYTES = 65536
) (
   input  logic             clk,
   input  logic             rst_n,
   boot_sequencer_if.master bus,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      WAIT_CALIB = 3'd0,
      CLEAR      = 3'd1,
      LOAD       = 3'd2,
      RUN        = 3'd3,
      ERROR      = 3'd4
   } state_t;

   localparam logic [16:0] LOAD_LAST = 17'(LOAD_BYTES);

   state_t      state;
   logic [16:0] byte_count;
   logic        clear_req_q;
   logic        clear_done_q;
   logic        wr_req_q;
   logic [15:0] wr_addr_q;
   logic [7:0]  wr_data_q;
   logic        load_done_q;
   logic [7:0]  progress_q;
   logic        cpu_run_q;
   logic        boot_error_q;
   logic [1:0]  error_code_q;

   logic [16:0] cnt_inc;
   logic        wr_done;
   logic [1:0]  err_cause;

   assign cnt_inc = byte_count + 17'd1;
   assign wr_done = wr_req_q && bus.wr_ack;

   // Fault causes in priority order: mem_error, lost calibration, UART overrun.
   always_comb begin
      err_cause = 2'b00;
      if (state == CLEAR || state == LOAD || state == RUN) begin
         if (bus.mem_error)
            err_cause = 2'b01;
         else if (!bus.mem_calib_done)
            err_cause = 2'b11;
         else if (state == LOAD && bus.uart_valid && wr_req_q && !bus.wr_ack)
            err_cause = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_CALIB;
         byte_count   <= '0;
         clear_req_q  <= 1'b0;
         clear_done_q <= 1'b0;
         wr_req_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         load_done_q  <= 1'b0;
         progress_q   <= '0;
         cpu_run_q    <= 1'b0;
         boot_error_q <= 1'b0;
         error_code_q <= '0;
      end else if (err_cause != 2'b00) begin
         state        <= ERROR;
         error_code_q <= err_cause;
         boot_error_q <= 1'b1;
         clear_req_q  <= 1'b0;
         wr_req_q     <= 1'b0;
         cpu_run_q    <= 1'b0;
      end else begin
         case (state)
            WAIT_CALIB: begin
               if (bus.mem_calib_done) begin
                  state       <= CLEAR;
                  clear_req_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (bus.clear_ack) begin
                  state        <= LOAD;
                  clear_req_q  <= 1'b0;
                  clear_done_q <= 1'b1;
               end
            end
            LOAD: begin
               progress_q <= byte_count[15:8];
               if (wr_done) begin
                  byte_count <= cnt_inc;
                  if (cnt_inc == LOAD_LAST) begin
                     state       <= RUN;
                     wr_req_q    <= 1'b0;
                     load_done_q <= 1'b1;
                     progress_q  <= 8'hFF;
                     cpu_run_q   <= 1'b1;
                  end else if (bus.uart_valid) begin
                     // Back-to-back byte: reuse the request, next address.
                     wr_addr_q <= cnt_inc[15:0];
                     wr_data_q <= bus.uart_data;
                  end else begin
                     wr_req_q <= 1'b0;
                  end
               end else if (!wr_req_q && bus.uart_valid) begin
                  wr_req_q  <= 1'b1;
                  wr_addr_q <= byte_count[15:0];
                  wr_data_q <= bus.uart_data;
               end
            end
            RUN: begin
               cpu_run_q <= 1'b1;
            end
            default: begin
               // ERROR holds everything until reset.
            end
         endcase
      end
   end

   assign bus.clear_req         = clear_req_q;
   assign bus.clear_screen_done = clear_done_q;
   assign bus.wr_req            = wr_req_q;
   assign bus.wr_addr           = wr_addr_q;
   assign bus.wr_data           = wr_data_q;
   assign bus.uart_load_done    = load_done_q;
   assign bus.uart_progress     = progress_q;
   assign bus.cpu_run           = cpu_run_q;
   assign bus.boot_error        = boot_error_q;
   assign bus.error_code        = error_code_q;
   assign state_dbg             = state;

endmodule
